// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC command sequencer: PCL/PCH load, increment and bus-drive strobes
// Optional macro PC_SEQUENCER_AOUT_INC_EN: AOUT also increments the PC (fetch overlapped with address phase).
module pc_sequencer #(
  parameter int CMD_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic             cmd_ready,
  input  logic             br_sign,
  input  logic             br_carry,
  output logic             pcl_adlwa,
  output logic             pcl_inc,
  output logic             pcl_adloa,
  output logic             pcl_dboa,
  output logic             pch_adhwa,
  output logic             pch_inc,
  output logic             pch_pclc,
  output logic             pch_adhoa,
  output logic             pch_dboa,
  output logic             fix_dir,
  output logic             busy,
  output logic             done
);

  localparam logic [CMD_W-1:0] CMD_FETCH  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_JUMP   = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_BRANCH = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_PUSH   = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_AOUT   = CMD_W'(5);

`ifdef PC_SEQUENCER_AOUT_INC_EN
  localparam logic AOUT_INC = 1'b1;
`else
  localparam logic AOUT_INC = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_JUMP, S_BR_ADD, S_BR_FIX, S_PUSH_H, S_PUSH_L, S_AOUT
  } state_t;

  state_t state, state_nxt;
  logic   sign_q;
  logic   done_q;
  logic   br_fix;

  assign br_fix  = br_carry ^ sign_q;
  assign pch_inc = 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_FETCH:  state_nxt = S_FETCH;
            CMD_JUMP:   state_nxt = S_JUMP;
            CMD_BRANCH: state_nxt = S_BR_ADD;
            CMD_PUSH:   state_nxt = S_PUSH_H;
            CMD_AOUT:   state_nxt = S_AOUT;
            default:    state_nxt = S_IDLE;
          endcase
        end
      end
      S_BR_ADD: state_nxt = br_fix ? S_BR_FIX : S_IDLE;
      S_PUSH_H: state_nxt = S_PUSH_L;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      fix_dir   <= 1'b0;
      pcl_adlwa <= 1'b0;
      pcl_inc   <= 1'b0;
      pcl_adloa <= 1'b0;
      pcl_dboa  <= 1'b0;
      pch_adhwa <= 1'b0;
      pch_pclc  <= 1'b0;
      pch_adhoa <= 1'b0;
      pch_dboa  <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (state == S_IDLE && cmd_valid)
        sign_q  <= br_sign;
      done_q    <= (state_nxt == S_FETCH) || (state_nxt == S_JUMP) ||
                   (state_nxt == S_BR_FIX) || (state_nxt == S_PUSH_L) ||
                   (state_nxt == S_AOUT);
      cmd_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      fix_dir   <= (state_nxt == S_BR_FIX) ? br_carry : 1'b0;
      pcl_adlwa <= (state_nxt == S_JUMP) || (state_nxt == S_BR_ADD);
      pcl_inc   <= (state_nxt == S_FETCH) || (AOUT_INC && state_nxt == S_AOUT);
      pcl_adloa <= (state_nxt == S_AOUT);
      pcl_dboa  <= (state_nxt == S_PUSH_L);
      pch_adhwa <= (state_nxt == S_JUMP) || (state_nxt == S_BR_FIX);
      pch_pclc  <= (state_nxt == S_FETCH) || (AOUT_INC && state_nxt == S_AOUT);
      pch_adhoa <= (state_nxt == S_AOUT);
      pch_dboa  <= (state_nxt == S_PUSH_H);
    end
  end

  // A no-fix branch finishes in BR_ADD itself, which depends on the carry seen during that cycle.
  assign done = done_q | ((state == S_BR_ADD) && !br_fix);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer with a small PC datapath model
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic       cmd_ready;
  logic       br_sign = 1'b0;
  logic       br_carry = 1'b0;
  logic       pcl_adlwa, pcl_inc, pcl_adloa, pcl_dboa;
  logic       pch_adhwa, pch_inc, pch_pclc, pch_adhoa, pch_dboa;
  logic       fix_dir, busy, done;

  logic [7:0] adl = 8'h00;
  logic [7:0] adh = 8'h00;
  logic [7:0] pcl_m = 8'h00;
  logic [7:0] pch_m = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [8:0] ST_NONE   = 9'h000;
  localparam logic [8:0] ST_JUMP   = 9'b1_0_0_0_1_0_0_0_0;
  localparam logic [8:0] ST_FETCH  = 9'b0_1_0_0_0_0_1_0_0;
  localparam logic [8:0] ST_BRADD  = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] ST_BRFIX  = 9'b0_0_0_0_1_0_0_0_0;
  localparam logic [8:0] ST_PUSHH  = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] ST_PUSHL  = 9'b0_0_0_1_0_0_0_0_0;
`ifdef PC_SEQUENCER_AOUT_INC_EN
  localparam logic [8:0] ST_AOUT   = 9'b0_1_1_0_0_0_1_1_0;
`else
  localparam logic [8:0] ST_AOUT   = 9'b0_0_1_0_0_0_0_1_0;
`endif

  logic [8:0] strobes;
  assign strobes = {pcl_adlwa, pcl_inc, pcl_adloa, pcl_dboa,
                    pch_adhwa, pch_inc, pch_pclc, pch_adhoa, pch_dboa};

  pc_sequencer #(.CMD_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .br_sign(br_sign), .br_carry(br_carry),
    .pcl_adlwa(pcl_adlwa), .pcl_inc(pcl_inc), .pcl_adloa(pcl_adloa), .pcl_dboa(pcl_dboa),
    .pch_adhwa(pch_adhwa), .pch_inc(pch_inc), .pch_pclc(pch_pclc), .pch_adhoa(pch_adhoa),
    .pch_dboa(pch_dboa), .fix_dir(fix_dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference PC datapath driven by the strobes.
  always @(posedge clk) begin
    if (pcl_adlwa)    pcl_m <= adl;
    else if (pcl_inc) pcl_m <= pcl_m + 8'h01;
    if (pch_adhwa) pch_m <= adh;
    else if (pch_inc || (pch_pclc && pcl_inc && pcl_m == 8'hFF)) pch_m <= pch_m + 8'h01;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("inv_db", 32'(pcl_dboa & pch_dboa), 32'd0);
    check("inv_pcl", 32'(pcl_adlwa & pcl_inc), 32'd0);
    check("inv_pch", 32'((pch_adhwa & pch_inc) | (pch_adhwa & pch_pclc)), 32'd0);
    if (state_is_idle()) check("inv_fixdir", 32'(fix_dir), 32'd0);
  endtask

  function automatic logic state_is_idle();
    return !busy;
  endfunction

  task automatic issue(input logic [2:0] c, input logic s);
    cmd_valid = 1'b1;
    cmd = c;
    br_sign = s;
    tick();
    cmd_valid = 1'b0;
    cmd = $urandom_range(7, 0);
  endtask

  task automatic jump_to(input logic [15:0] pc);
    adl = pc[7:0];
    adh = pc[15:8];
    issue(3'd2, 1'b0);
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_strobes", 32'(strobes), 32'(ST_NONE));
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // JUMP
    adl = 8'h34; adh = 8'h12;
    issue(3'd2, 1'b0);
    check("jump_strobes", 32'(strobes), 32'(ST_JUMP));
    check("jump_done", 32'(done), 32'd1);
    check("jump_busy", 32'(busy), 32'd1);
    check("jump_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("jump_done_end", 32'(done), 32'd0);
    check("jump_pc", 32'({pch_m, pcl_m}), 32'h1234);

    // FETCH without and with PCL wrap
    issue(3'd1, 1'b0);
    check("fetch_strobes", 32'(strobes), 32'(ST_FETCH));
    check("fetch_done", 32'(done), 32'd1);
    tick();
    check("fetch_pc", 32'({pch_m, pcl_m}), 32'h1235);
    jump_to(16'h10FF);
    issue(3'd1, 1'b0);
    tick();
    check("fetch_wrap_pc", 32'({pch_m, pcl_m}), 32'h1100);

    // Forward branch crossing a page: 0x12F0 + 0x20
    jump_to(16'h12F0);
    adl = 8'h10; br_carry = 1'b1;
    issue(3'd3, 1'b0);
    check("bradd_strobes", 32'(strobes), 32'(ST_BRADD));
    check("bradd_done", 32'(done), 32'd0);
    check("bradd_fixdir", 32'(fix_dir), 32'd0);
    adh = 8'h13;
    tick();
    br_carry = 1'b0;
    check("brfix_strobes", 32'(strobes), 32'(ST_BRFIX));
    check("brfix_fixdir", 32'(fix_dir), 32'd1);
    check("brfix_done", 32'(done), 32'd1);
    tick();
    check("brfix_pc", 32'({pch_m, pcl_m}), 32'h1310);
    check("brfix_idle", 32'(busy), 32'd0);

    // Backward branch without page cross: 0x1220 - 0x10
    jump_to(16'h1220);
    adl = 8'h10; br_carry = 1'b1;
    issue(3'd3, 1'b1);
    check("brnf_strobes", 32'(strobes), 32'(ST_BRADD));
    check("brnf_done", 32'(done), 32'd1);
    tick();
    br_carry = 1'b0;
    check("brnf_busy", 32'(busy), 32'd0);
    check("brnf_pc", 32'({pch_m, pcl_m}), 32'h1210);

    // PUSH
    issue(3'd4, 1'b0);
    check("pushh_strobes", 32'(strobes), 32'(ST_PUSHH));
    check("pushh_done", 32'(done), 32'd0);
    tick();
    check("pushl_strobes", 32'(strobes), 32'(ST_PUSHL));
    check("pushl_done", 32'(done), 32'd1);
    tick();
    check("push_end", 32'(strobes), 32'(ST_NONE));

    // Back-to-back with cmd_valid held high; cmd change while busy is ignored
    adl = 8'h55; adh = 8'h66;
    cmd_valid = 1'b1; cmd = 3'd1;
    tick();
    check("b2b_first", 32'(strobes), 32'(ST_FETCH));
    cmd = 3'd2;
    tick();
    check("b2b_gap_ready", 32'(cmd_ready), 32'd1);
    check("b2b_gap_strobes", 32'(strobes), 32'(ST_NONE));
    tick();
    cmd_valid = 1'b0;
    check("b2b_second", 32'(strobes), 32'(ST_JUMP));
    tick();
    check("b2b_pc", 32'({pch_m, pcl_m}), 32'h6655);

    // AOUT
    jump_to(16'h20FF);
    issue(3'd5, 1'b0);
    check("aout_strobes", 32'(strobes), 32'(ST_AOUT));
    check("aout_done", 32'(done), 32'd1);
    tick();
`ifdef PC_SEQUENCER_AOUT_INC_EN
    check("aout_pc", 32'({pch_m, pcl_m}), 32'h2100);
`else
    check("aout_pc", 32'({pch_m, pcl_m}), 32'h20FF);
`endif

    // NOP codes
    issue(3'd0, 1'b0);
    check("nop0_busy", 32'(busy), 32'd0);
    check("nop0_done", 32'(done), 32'd0);
    issue(3'd7, 1'b0);
    check("nop7_ready", 32'(cmd_ready), 32'd1);
    check("nop7_strobes", 32'(strobes), 32'(ST_NONE));

    // Asynchronous reset in the middle of PUSH_H
    issue(3'd4, 1'b0);
    check("rstpush_pre", 32'(pch_dboa), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstpush_strobes", 32'(strobes), 32'(ST_NONE));
    check("rstpush_ready", 32'(cmd_ready), 32'd1);
    check("rstpush_busy", 32'(busy), 32'd0);
    check("rstpush_done", 32'(done), 32'd0);
    tick();
    check("rstpush_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rstpush_after_done", 32'(done), 32'd0);
    check("rstpush_after_strobes", 32'(strobes), 32'(ST_NONE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control sequencer for the split program counter: the PCL byte register and the PCH byte register (`pchigh`).
- Accepts one PC command at a time from the instruction decoder over a valid/ready handshake.
- Expands each command into cycle-exact load, increment and bus-output strobes for both PC halves.
- Handles multi-cycle operations: relative-branch page fix-up and PC push (high byte, then low byte).

Parameters:
- CMD_W, 3, width of the command code.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  decoder presents a command.
- cmd  input  CMD_W  command code: 0 NOP, 1 FETCH, 2 JUMP, 3 BRANCH, 4 PUSH, 5 AOUT. Codes 6 and 7 are treated as NOP.
- cmd_ready  output  1  high only in IDLE.
- br_sign  input  1  sign bit of the branch offset; sampled on BRANCH acceptance.
- br_carry  input  1  ALU carry out of PCL+offset; sampled at the end of BR_ADD.
- pcl_adlwa  output  1  PCL loads from the ADL bus.
- pcl_inc  output  1  PCL increments.
- pcl_adloa  output  1  PCL drives ADL.
- pcl_dboa  output  1  PCL drives DB.
- pch_adhwa  output  1  PCH loads from the ADH bus.
- pch_inc  output  1  PCH increment enable.
- pch_pclc  output  1  PCH increments only on PCL carry.
- pch_adhoa  output  1  PCH drives ADH.
- pch_dboa  output  1  PCH drives DB.
- fix_dir  output  1  ALU fix-up direction during BR_FIX: 1 = PCH+1, 0 = PCH−1.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse on the last cycle of a command.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE immediately; every strobe, fix_dir, busy and done go to 0; cmd_ready goes to 1.
  - Reset asserted mid-command aborts it; no done is produced.
- Handshake:
  - A command is accepted on a rising clk edge when cmd_valid=1 and cmd_ready=1.
  - cmd and br_sign are registered at that edge.
  - No further command is accepted until the sequencer returns to IDLE.
- Latency: all strobes are Moore outputs decoded from state. They are asserted in the cycle after acceptance.
- NOP (codes 0, 6, 7): accepted, with no state change and no done.
- States and their outputs:
  - IDLE: all strobes 0.
  - FETCH (1 cycle): pcl_inc=1, pch_pclc=1, done=1, then IDLE. PCH increments only if PCL wraps FF→00.
  - JUMP (1 cycle): pcl_adlwa=1, pch_adhwa=1, done=1, then IDLE.
  - BR_ADD: pcl_adlwa=1. At the edge ending BR_ADD, fix = br_carry XOR br_sign.
    - fix=0: done=1 in BR_ADD, then IDLE (2 cycles total including acceptance).
    - fix=1: go to BR_FIX.
  - BR_FIX (1 cycle): pch_adhwa=1, fix_dir=br_carry (1 for a forward page cross, 0 for a backward one), done=1, then IDLE.
  - PUSH_H → PUSH_L: PUSH_H asserts pch_dboa=1; PUSH_L asserts pcl_dboa=1 and done=1, then IDLE.
  - AOUT (1 cycle): pcl_adloa=1, pch_adhoa=1, done=1, then IDLE.
- Invariants (the bench asserts these every cycle):
  - Never both pcl_dboa and pch_dboa.
  - Never a load and an increment on the same half.
  - Never pch_pclc together with pch_adhwa.
- Boundaries:
  - cmd_valid held high continuously: back-to-back commands have one IDLE cycle between them.
  - cmd changing while busy is ignored.
  - br_carry is ignored outside BR_ADD.
  - fix_dir=0 whenever the state is not BR_FIX.

Optional Feature:
- Macro: PC_SEQUENCER_AOUT_INC_EN.
- When defined, AOUT also asserts pcl_inc=1 and pch_pclc=1 in the same cycle. This increments the PC while it is driven as the address, i.e. a fetch overlapped with the address phase.
- When undefined, AOUT only drives the address buses.
- In both cases, the PC value driven during AOUT is the pre-increment value.

Test Plan:
- Reset with rst_n=0 asserted mid-PUSH_H → strobes drop within the same cycle with no clk edge, cmd_ready=1, and no done.
- FETCH accepted at edge N → cycle N+1: pcl_inc=1, pch_pclc=1, done=1. With PC=0x10FF, PC becomes 0x1100; with PC=0x1234, PC becomes 0x1235.
- JUMP with ADL=0x34, ADH=0x12 → one cycle with pcl_adlwa=pch_adhwa=1 → PC=0x1234, done pulses once.
- BRANCH, PC=0x12F0, offset +0x20 (br_sign=0, br_carry=1) → BR_ADD then BR_FIX with fix_dir=1 → done on the 2nd strobe cycle.
- BRANCH, offset −0x10 from 0x1220 (br_sign=1, br_carry=1) → no BR_FIX, done in BR_ADD.
- PUSH → pch_dboa for exactly 1 cycle, then pcl_dboa for 1 cycle with done. With cmd_valid held high, the next command is accepted 1 cycle after done. AOUT with and without PC_SEQUENCER_AOUT_INC_EN → pcl_inc is 1 with the macro and 0 without it.
